// File: rtl/display_phase_ctrl.sv
// Game-phase sequencer for the VGA layer mux: frame-synchronous phase FSM that
// drives per-layer enables, the RGB dimmer fade level and the loot reload pulse.
module display_phase_ctrl #(
    parameter int FADE_FRAMES  = 8,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 16,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start_game,
    input  logic       level_done,
    input  logic       time_up,
    input  logic       restart,
    input  logic       time_low,
    output logic [6:0] layer_en,
    output logic       title_en,
    output logic [1:0] fade_level,
    output logic [2:0] phase,
    output logic [3:0] level_idx,
    output logic       new_level
);

    localparam logic [2:0] S_TITLE     = 3'd0;
    localparam logic [2:0] S_FADE_IN   = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_LEVEL_END = 3'd3;
    localparam logic [2:0] S_FADE_OUT  = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;

    localparam logic [6:0] MASK_TITLE = 7'b0000001;
    localparam logic [6:0] MASK_ALL   = 7'b1111111;
    localparam logic [6:0] MASK_LEND  = 7'b0100101;
    localparam logic [6:0] MASK_OVER  = 7'b0100001;

    localparam logic [7:0] FADE_THR  = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] HOLD_THR  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_THR = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0] LVL_MAX   = 4'(MAX_LEVEL);

    // pend bit order: [3]restart [2]time_up [1]level_done [0]start_game
    logic [3:0] pend, pend_nx, ev_in, ev;
    logic [2:0] state, state_nx;
    logic [6:0] layer_nx;
    logic       title_nx;
    logic [1:0] fade_nx;
    logic [3:0] level_nx;
    logic       newl_nx;
    logic [7:0] frame_cnt, frame_nx, frame_inc;
    logic       blink, blink_nx;
    logic [7:0] blink_cnt, bcnt_nx;
    logic       go_over, go_nx;

    assign ev_in     = {restart, time_up, level_done, start_game};
    assign ev        = pend | ev_in;
    assign pend_nx   = startOfFrame ? 4'b0000 : ev;
    assign frame_inc = frame_cnt + 8'd1;
    assign phase     = state;

    always_comb begin
        state_nx = state;
        layer_nx = layer_en;
        title_nx = title_en;
        fade_nx  = fade_level;
        level_nx = level_idx;
        newl_nx  = 1'b0;
        frame_nx = frame_cnt;
        blink_nx = blink;
        bcnt_nx  = blink_cnt;
        go_nx    = go_over;
        if (startOfFrame) begin
            frame_nx = frame_inc;
            // Blink only runs in PLAY; everywhere else it idles visible.
            blink_nx = 1'b1;
            bcnt_nx  = 8'd0;
            case (state)
                S_TITLE: begin
                    if (ev[0]) begin
                        state_nx = S_FADE_IN;
                        layer_nx = MASK_ALL;
                        title_nx = 1'b0;
                        fade_nx  = 2'd3;
                        level_nx = 4'd0;
                        newl_nx  = 1'b1;
                        frame_nx = 8'd0;
                    end
                end
                S_FADE_IN: begin
                    if (ev[3]) begin
                        state_nx = S_TITLE;
                        layer_nx = MASK_TITLE;
                        title_nx = 1'b1;
                        fade_nx  = 2'd3;
                        frame_nx = 8'd0;
                    end else if (frame_cnt == FADE_THR) begin
                        frame_nx = 8'd0;
                        if (fade_level <= 2'd1) begin
                            state_nx = S_PLAY;
                            fade_nx  = 2'd0;
                            layer_nx = MASK_ALL;
                        end else begin
                            fade_nx = fade_level - 2'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (time_low) begin
                        if (blink_cnt == BLINK_THR) begin
                            blink_nx = ~blink;
                            bcnt_nx  = 8'd0;
                        end else begin
                            blink_nx = blink;
                            bcnt_nx  = blink_cnt + 8'd1;
                        end
                    end
                    layer_nx = {5'b11111, blink_nx, 1'b1};
                    if (ev[2]) begin
                        state_nx = S_FADE_OUT;
                        go_nx    = 1'b1;
                        blink_nx = 1'b1;
                        bcnt_nx  = 8'd0;
                        layer_nx = MASK_ALL;
                        frame_nx = 8'd0;
                    end else if (ev[1]) begin
                        state_nx = S_LEVEL_END;
                        blink_nx = 1'b1;
                        bcnt_nx  = 8'd0;
                        layer_nx = MASK_LEND;
                        frame_nx = 8'd0;
                    end else if (ev[3]) begin
                        state_nx = S_TITLE;
                        blink_nx = 1'b1;
                        bcnt_nx  = 8'd0;
                        layer_nx = MASK_TITLE;
                        title_nx = 1'b1;
                        fade_nx  = 2'd3;
                        frame_nx = 8'd0;
                    end
                end
                S_LEVEL_END: begin
                    if (ev[3]) begin
                        state_nx = S_TITLE;
                        layer_nx = MASK_TITLE;
                        title_nx = 1'b1;
                        fade_nx  = 2'd3;
                        frame_nx = 8'd0;
                    end else if (frame_cnt == HOLD_THR) begin
                        state_nx = S_FADE_OUT;
                        go_nx    = 1'b0;
                        frame_nx = 8'd0;
                    end
                end
                S_FADE_OUT: begin
                    if (ev[3]) begin
                        state_nx = S_TITLE;
                        layer_nx = MASK_TITLE;
                        title_nx = 1'b1;
                        fade_nx  = 2'd3;
                        frame_nx = 8'd0;
                    end else if (frame_cnt == FADE_THR) begin
                        frame_nx = 8'd0;
                        if (fade_level >= 2'd2) begin
                            if (go_over) begin
                                state_nx = S_GAME_OVER;
                                layer_nx = MASK_OVER;
                                fade_nx  = 2'd0;
                            end else begin
                                state_nx = S_FADE_IN;
                                layer_nx = MASK_ALL;
                                fade_nx  = 2'd3;
                                level_nx = (level_idx >= LVL_MAX) ? 4'd0 : level_idx + 4'd1;
                                newl_nx  = 1'b1;
                            end
                        end else begin
                            fade_nx = fade_level + 2'd1;
                        end
                    end
                end
                S_GAME_OVER: begin
                    if (ev[3]) begin
                        state_nx = S_TITLE;
                        layer_nx = MASK_TITLE;
                        title_nx = 1'b1;
                        fade_nx  = 2'd3;
                        frame_nx = 8'd0;
                    end
                end
                default: begin
                    state_nx = S_TITLE;
                    layer_nx = MASK_TITLE;
                    title_nx = 1'b1;
                    fade_nx  = 2'd3;
                    frame_nx = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_TITLE;
            layer_en   <= MASK_TITLE;
            title_en   <= 1'b1;
            fade_level <= 2'd3;
            level_idx  <= 4'd0;
            new_level  <= 1'b0;
            pend       <= 4'b0000;
            frame_cnt  <= 8'd0;
            blink      <= 1'b1;
            blink_cnt  <= 8'd0;
            go_over    <= 1'b0;
        end else begin
            state      <= state_nx;
            layer_en   <= layer_nx;
            title_en   <= title_nx;
            fade_level <= fade_nx;
            level_idx  <= level_nx;
            new_level  <= newl_nx;
            pend       <= pend_nx;
            frame_cnt  <= frame_nx;
            blink      <= blink_nx;
            blink_cnt  <= bcnt_nx;
            go_over    <= go_nx;
        end
    end

endmodule

// File: tb/tb_display_phase_ctrl.sv
// Directed bench for display_phase_ctrl: walks every phase with hand-computed
// expectations at fixed frame counts (4 cycles per frame or more).
module tb_display_phase_ctrl;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       start_game;
    logic       level_done;
    logic       time_up;
    logic       restart;
    logic       time_low;
    logic [6:0] layer_en;
    logic       title_en;
    logic [1:0] fade_level;
    logic [2:0] phase;
    logic [3:0] level_idx;
    logic       new_level;

    int n_chk = 0;
    int n_fail = 0;
    int nl_total = 0;
    int nl_base = 0;

    display_phase_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .start_game(start_game), .level_done(level_done), .time_up(time_up),
        .restart(restart), .time_low(time_low), .layer_en(layer_en),
        .title_en(title_en), .fade_level(fade_level), .phase(phase),
        .level_idx(level_idx), .new_level(new_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (new_level === 1'b1) nl_total = nl_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ph, input logic [6:0] le,
                           input logic te, input logic [1:0] fl, input logic [3:0] li);
        chk({tag, ".phase"}, 32'(phase), 32'(ph));
        chk({tag, ".layer_en"}, 32'(layer_en), 32'(le));
        chk({tag, ".title_en"}, 32'(title_en), 32'(te));
        chk({tag, ".fade"}, 32'(fade_level), 32'(fl));
        chk({tag, ".level"}, 32'(level_idx), 32'(li));
    endtask

    // ev = {restart, time_up, level_done, start_game}, driven with startOfFrame
    task automatic tick(input logic [3:0] ev);
        @(negedge clk);
        startOfFrame = 1'b1;
        {restart, time_up, level_done, start_game} = ev;
        @(negedge clk);
        startOfFrame = 1'b0;
        {restart, time_up, level_done, start_game} = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(4'b0000);
    endtask

    task automatic pulse(input logic [3:0] ev);
        @(negedge clk);
        {restart, time_up, level_done, start_game} = ev;
        @(negedge clk);
        {restart, time_up, level_done, start_game} = 4'b0000;
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        {restart, time_up, level_done, start_game} = 4'b0000;
        time_low = 1'b0;
        @(negedge clk);
        chk_all("reset", 3'd0, 7'h01, 1'b1, 2'd3, 4'd0);
        chk("reset.new_level", 32'(new_level), 32'd0);
        resetN = 1'b1;
        ticks(3);
        chk_all("idle", 3'd0, 7'h01, 1'b1, 2'd3, 4'd0);

        // start mid-frame, fade-in 3,2,1,0
        nl_base = nl_total;
        pulse(4'b0001);
        tick(4'b0000);
        chk_all("fadein", 3'd1, 7'h7f, 1'b0, 2'd3, 4'd0);
        chk("fadein.nl", 32'(nl_total - nl_base), 32'd1);
        ticks(7);  chk("fade3", 32'(fade_level), 32'd3);
        ticks(1);  chk("fade2", 32'(fade_level), 32'd2);
        ticks(8);  chk("fade1", 32'(fade_level), 32'd1);
        ticks(7);  chk("fade1.hold", 32'(phase), 32'd1);
        ticks(1);  chk_all("play", 3'd2, 7'h7f, 1'b0, 2'd0, 4'd0);
        chk("play.nl", 32'(nl_total - nl_base), 32'd1);

        // timer blink
        time_low = 1'b1;
        ticks(15); chk("blink15", 32'(layer_en), 32'h7f);
        ticks(1);  chk("blink16", 32'(layer_en), 32'h7d);
        ticks(16); chk("blink32", 32'(layer_en), 32'h7f);
        ticks(16); chk("blink48", 32'(layer_en), 32'h7d);
        ticks(16); chk("blink64", 32'(layer_en), 32'h7f);
        ticks(16); chk("blink80", 32'(layer_en), 32'h7d);
        time_low = 1'b0;
        ticks(1);  chk("blink.drop", 32'(layer_en), 32'h7f);

        // time_up beats level_done
        pulse(4'b0110);
        tick(4'b0000);
        chk_all("fo_over", 3'd4, 7'h7f, 1'b0, 2'd0, 4'd0);
        ticks(8);  chk("fo.f1", 32'(fade_level), 32'd1);
        ticks(8);  chk("fo.f2", 32'(fade_level), 32'd2);
        ticks(7);  chk("fo.hold", 32'(phase), 32'd4);
        ticks(1);  chk_all("gameover", 3'd5, 7'h21, 1'b0, 2'd0, 4'd0);
        pulse(4'b0001);
        tick(4'b0000);
        chk("go.ignore_start", 32'(phase), 32'd5);
        pulse(4'b1000);
        tick(4'b0000);
        chk_all("go.restart", 3'd0, 7'h01, 1'b1, 2'd3, 4'd0);

        // level progression with wrap at MAX_LEVEL
        pulse(4'b0001);
        tick(4'b0000);
        ticks(24);
        chk("lv.play", 32'(phase), 32'd2);
        for (int it = 0; it <= 10; it++) begin
            if (it == 10) begin
                nl_base = nl_total;
                pulse(4'b0001);
                tick(4'b0000);
                chk("play.ignore_start", 32'(phase), 32'd2);
                chk("play.ignore_nl", 32'(nl_total - nl_base), 32'd0);
            end
            if (it == 0) tick(4'b1010);
            else begin
                pulse(4'b0010);
                tick(4'b0000);
            end
            chk_all("lvlend", 3'd3, 7'h25, 1'b0, 2'd0, 4'(it % 10));
            ticks(119); chk("lvlend.hold", 32'(phase), 32'd3);
            ticks(1);   chk_all("lvl_fo", 3'd4, 7'h25, 1'b0, 2'd0, 4'(it % 10));
            nl_base = nl_total;
            ticks(24);
            chk_all("nextlvl", 3'd1, 7'h7f, 1'b0, 2'd3, 4'((it + 1) % 10));
            chk("nextlvl.nl", 32'(nl_total - nl_base), 32'd1);
            if (it < 10) begin
                ticks(24);
                chk("nextlvl.play", 32'(phase), 32'd2);
            end
        end

        // asynchronous reset mid fade-in
        ticks(16);
        chk_all("midfade", 3'd1, 7'h7f, 1'b0, 2'd1, 4'd1);
        nl_base = nl_total;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk_all("async_rst", 3'd0, 7'h01, 1'b1, 2'd3, 4'd0);
        chk("async_rst.nl", 32'(new_level), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        ticks(3);
        chk("post_rst.phase", 32'(phase), 32'd0);
        chk("post_rst.nl", 32'(nl_total - nl_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_phase_ctrl.md
Name: display_phase_ctrl

Overview:
- Frame-synchronous game-phase sequencer that configures the VGA layer mux.
- Outputs per-layer enable masks, a fade level for the RGB dimmer, and a new-level pulse for loot reload.
- Walks the game through title, fade-in, play, level-end, fade-out and game-over phases.
- Sits between game-logic event sources and the layer drawing-request gating in front of the object mux.

Parameters:
- FADE_FRAMES, 8, frames per fade step (fade_level changes by 1 every FADE_FRAMES frames).
- HOLD_FRAMES, 120, frames spent in LEVEL_END before FADE_OUT.
- BLINK_FRAMES, 16, half-period in frames of the timer-layer blink while time_low.
- MAX_LEVEL, 9, highest level index; the level counter wraps to 0 after it.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- start_game  in  1  pulse: player start
- level_done  in  1  pulse: level target reached
- time_up  in  1  pulse: timer expired
- restart  in  1  pulse: return to title
- time_low  in  1  level: timer below threshold
- layer_en  out  7  [6]claw [5]scoreboard [4]claw_line [3]loot [2]miner [1]timer [0]background
- title_en  out  1  title MIF screen selected
- fade_level  out  2  0 = full brightness, 3 = darkest
- phase  out  3  TITLE=0 FADE_IN=1 PLAY=2 LEVEL_END=3 FADE_OUT=4 GAME_OVER=5
- level_idx  out  4  current level, 0..MAX_LEVEL
- new_level  out  1  one-cycle pulse when a level starts

Behaviour:
- Reset (asynchronous, resetN low):
  - State TITLE; layer_en=7'b0000001; title_en=1; fade_level=3; level_idx=0; new_level=0.
  - Pending flags, frame_cnt and blink state cleared.
- Event latching:
  - Each event pulse sets its own pending flag on the cycle it arrives.
  - Flags are evaluated only on cycles with startOfFrame=1.
  - A pulse arriving in the same cycle as startOfFrame is evaluated in that frame.
  - At every startOfFrame all pending flags clear, whether consumed or discarded. Events irrelevant to the current state are dropped.
- Event priority within one evaluation: time_up > level_done > restart > start_game.
- Timing: all outputs are registered. A transition evaluated at startOfFrame in cycle N is visible at cycle N+1. Outputs never change mid-frame except new_level, which is high for exactly cycle N+1 only.
- frame_cnt:
  - 8-bit; increments at each startOfFrame; cleared on state entry.
  - On reaching a step threshold (FADE_FRAMES or HOLD_FRAMES), acts and clears.
- State transitions:
  - TITLE: start_game → FADE_IN; level_idx=0; new_level pulse.
  - FADE_IN: mask 7'b1111111. fade_level decrements every FADE_FRAMES frames; the step 1→0 transitions to PLAY.
  - PLAY:
    - mask 7'b1111111 with bit1 = blink.
    - blink toggles every BLINK_FRAMES frames while time_low=1.
    - blink is forced to 1 and its counter cleared when time_low=0.
    - time_up → FADE_OUT with go_over=1.
    - level_done → LEVEL_END.
  - LEVEL_END: mask 7'b0100101. After HOLD_FRAMES frames → FADE_OUT with go_over=0.
  - FADE_OUT:
    - mask held from the previous state; blink forced to 1.
    - fade_level increments every FADE_FRAMES frames.
    - The step 2→3 exits:
      - go_over=1 → GAME_OVER.
      - otherwise → FADE_IN, with level_idx incremented and a new_level pulse.
    - level_idx at MAX_LEVEL wraps to 0.
  - GAME_OVER: mask 7'b0100001; fade_level=0; restart → TITLE (fade_level=3, title_en=1).
  - restart in FADE_IN, PLAY, LEVEL_END or FADE_OUT → TITLE immediately at that frame boundary. It is overridden by time_up/level_done when those are applicable in the same frame.
- title_en=1 only in TITLE.
- fade_level saturates at 0 and 3; no wrap.
- Reset mid-fade or mid-play returns to the reset values immediately, with no further new_level pulse.

Test Plan:
- Reset, then 3 frames without events → phase=0, layer_en=7'b0000001, title_en=1, fade_level=3, level_idx=0.
- start_game one cycle mid-frame → at next startOfFrame+1: phase=1 and a single new_level pulse; fade_level steps 3,2,1,0 at 8-frame intervals; phase=2 one cycle after the 0 step.
- PLAY with time_low=1 for 64 frames → layer_en[1] toggles every 16 frames, other bits stay 1. Dropping time_low → bit1=1 at the next frame.
- level_done and time_up in the same frame → FADE_OUT with go_over=1, ending in phase=5 with layer_en=7'b0100001 and level_idx unchanged.
- level_done at level_idx=9 → LEVEL_END for 120 frames, FADE_OUT, then FADE_IN with level_idx=0 and one new_level pulse.
- resetN low mid-FADE_IN (fade_level=1) → outputs at reset values within the same cycle; start_game pulses while in PLAY have no effect.
